// File: rtl/rtype_ctrl_seq.sv
// Hardwired fetch/execute control sequencer for data_path: register-register ALU ops
// (two-operand, one-operand) and MUL/DIV with HI/LO writeback.
module rtype_ctrl_seq #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic             mem_ready,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             ZHighin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic [OPW-1:0]   op,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        C_BIN = 2'd0,
        C_UN  = 2'd1,
        C_HL  = 2'd2,
        C_ILL = 2'd3
    } cls_e;

    function automatic cls_e decode_class(input logic [4:0] opc);
        cls_e c;
        case (opc)
            5'h0F, 5'h10: c = C_HL;
            5'h11, 5'h12: c = C_UN;
            default: begin
                if (opc <= 5'h0E) begin
                    c = C_BIN;
                end else begin
                    c = C_ILL;
                end
            end
        endcase
        return c;
    endfunction

    function automatic logic [NREGS-1:0] reg_onehot(input logic [3:0] idx);
        logic [NREGS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        t1_wait_q, t1_wait_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    logic [4:0]  opc_s;
    logic [3:0]  ra_s, rb_s, rc_s;
    cls_e        cls_s;
    logic        ir_unused_s;

    assign opc_s       = ir_q[31:27];
    assign ra_s        = ir_q[26:23];
    assign rb_s        = ir_q[22:19];
    assign rc_s        = ir_q[18:15];
    assign cls_s       = decode_class(opc_s);
    assign ir_unused_s = ^ir_q[14:0];

    // State, latched instruction, T1 wait flag and completion pulses.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'h0000_0000;
            t1_wait_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            t1_wait_q <= t1_wait_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing; t1_wait marks T1 cycles after the first so PC loads once.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        t1_wait_d = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else begin
                    state_d   = S_T1;
                    t1_wait_d = 1'b1;
                end
            end
            S_T2: begin
                ir_d    = IR;
                state_d = S_T3;
            end
            S_T3: begin
                if (cls_s == C_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls_s == C_HL) begin
                    state_d = S_T6;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T6: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobe decode from the state register and latched IR only.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        ZHighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rout     = '0;
        Rin      = '0;
        op       = '0;
        case (state_q)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = ~t1_wait_q;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if ((cls_s == C_BIN) || (cls_s == C_HL)) begin
                    Rout = reg_onehot(rb_s);
                    Yin  = 1'b1;
                end else begin
                    Yin = 1'b0;
                end
            end
            S_T4: begin
                op = OPW'(opc_s);
                case (cls_s)
                    C_BIN: begin
                        Rout   = reg_onehot(rc_s);
                        Zlowin = 1'b1;
                    end
                    C_UN: begin
                        Rout   = reg_onehot(rb_s);
                        Zlowin = 1'b1;
                    end
                    C_HL: begin
                        Rout    = reg_onehot(rc_s);
                        Zlowin  = 1'b1;
                        ZHighin = 1'b1;
                    end
                    default: Rout = '0;
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (cls_s == C_HL) begin
                    LOin = 1'b1;
                end else begin
                    Rin = reg_onehot(ra_s);
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: op = '0;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_rtype_ctrl_seq.sv
// Directed per-cycle vector bench for rtype_ctrl_seq: each table row gives the inputs for
// one cycle and the hand-derived outputs expected in that cycle.
module tb_rtype_ctrl_seq;

    logic        Clock, clear, start, mem_ready;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic [4:0]  op;
    logic        busy, done, illegal;

    rtype_ctrl_seq #(.NREGS(16), .OPW(5)) dut (
        .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .ZHighin(ZHighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rout(Rout), .Rin(Rin), .op(op), .busy(busy), .done(done), .illegal(illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [14:0] K_PCOUT  = 15'h4000, K_MARIN = 15'h2000, K_INCPC  = 15'h1000;
    localparam logic [14:0] K_PCIN   = 15'h0800, K_READ  = 15'h0400, K_MDRIN  = 15'h0200;
    localparam logic [14:0] K_MDROUT = 15'h0100, K_IRIN  = 15'h0080, K_YIN    = 15'h0040;
    localparam logic [14:0] K_ZLIN   = 15'h0020, K_ZHIN  = 15'h0010, K_ZLOUT  = 15'h0008;
    localparam logic [14:0] K_ZHOUT  = 15'h0004, K_HIIN  = 15'h0002, K_LOIN   = 15'h0001;
    localparam logic [14:0] K_T0  = K_PCOUT | K_MARIN | K_INCPC | K_ZLIN;
    localparam logic [14:0] K_T1F = K_ZLOUT | K_PCIN | K_READ | K_MDRIN;
    localparam logic [14:0] K_T1W = K_ZLOUT | K_READ | K_MDRIN;
    localparam logic [14:0] K_T2  = K_MDROUT | K_IRIN;

    localparam logic [31:0] I_BIN  = 32'h1891_8000; // sll R1,R2,R3
    localparam logic [31:0] I_HL   = 32'h7822_8000; // mul R4,R5
    localparam logic [31:0] I_ILL  = 32'hF800_0000;
    localparam logic [31:0] I_UN   = 32'h8B38_0000; // neg R6,R7
    localparam logic [31:0] I_SAME = 32'h77FF_8000; // opc 0x0E, Ra=Rb=Rc=15

    typedef struct {
        logic        st, mr, clr;
        logic [31:0] ir;
        logic [14:0] ctrl;
        logic [15:0] rout, rin;
        logic [4:0]  op;
        logic        busy, done, ill;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic st, input logic mr, input logic clr, input logic [31:0] ir,
                       input logic [14:0] ctrl, input logic [15:0] rout, input logic [15:0] rin,
                       input logic [4:0] o, input logic b, input logic d, input logic il);
        vec_t v;
        v.st = st; v.mr = mr; v.clr = clr; v.ir = ir; v.ctrl = ctrl;
        v.rout = rout; v.rin = rin; v.op = o; v.busy = b; v.done = d; v.ill = il;
        tbl.push_back(v);
    endtask

    // T0, T1 (nwait stalled cycles then mem_ready), T2
    task automatic fetch(input logic [31:0] ir, input int nwait, input logic st);
        add(st, 1'b0, 1'b0, ir, K_T0, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nwait; i++)
            add(st, 1'b0, 1'b0, ir, (i == 0) ? K_T1F : K_T1W, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        add(st, 1'b1, 1'b0, ir, (nwait == 0) ? K_T1F : K_T1W, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        add(st, 1'b0, 1'b0, ir, K_T2, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic st, input logic [31:0] ir, input logic d, input logic il);
        add(st, 1'b0, 1'b0, ir, 15'h0, 16'h0, 16'h0, 5'h00, 1'b0, d, il);
    endtask

    task automatic bin_exec(input logic [31:0] ir);
        add(1'b0, 1'b0, 1'b0, ir, K_YIN,  16'h0004, 16'h0000, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, ir, K_ZLIN, 16'h0008, 16'h0000, 5'h03, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, ir, K_ZLOUT, 16'h0000, 16'h0002, 5'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b0, ir, 1'b1, 1'b0);
    endtask

    initial begin
        logic [54:0] act, exp_v;
        int          drivers;

        // Reset state, then BIN with no memory wait: done in cycle 7 after start.
        idle(1'b0, I_BIN, 1'b0, 1'b0);
        idle(1'b1, I_BIN, 1'b0, 1'b0);
        fetch(I_BIN, 0, 1'b0);
        bin_exec(I_BIN);
        idle(1'b0, I_BIN, 1'b0, 1'b0);

        // Memory wait of 3 cycles; IR input changes after T2 to prove the latch is used.
        idle(1'b1, I_BIN, 1'b0, 1'b0);
        fetch(I_BIN, 3, 1'b0);
        bin_exec(I_ILL);
        idle(1'b0, I_ILL, 1'b0, 1'b0);

        // HL with start held high throughout, then back-to-back into an illegal opcode.
        idle(1'b1, I_HL, 1'b0, 1'b0);
        fetch(I_HL, 0, 1'b1);
        add(1'b1, 1'b0, 1'b0, I_HL, K_YIN,           16'h0010, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, I_HL, K_ZLIN | K_ZHIN, 16'h0020, 16'h0, 5'h0F, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, I_HL, K_ZLOUT | K_LOIN, 16'h0,   16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, I_HL, K_ZHOUT | K_HIIN, 16'h0,   16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b1, I_ILL, 1'b1, 1'b0);
        fetch(I_ILL, 0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_ILL, 15'h0, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b0, I_ILL, 1'b0, 1'b1);
        idle(1'b0, I_ILL, 1'b0, 1'b0);

        // One-operand neg R6,R7.
        idle(1'b1, I_UN, 1'b0, 1'b0);
        fetch(I_UN, 0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_UN, 15'h0,   16'h0000, 16'h0000, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_UN, K_ZLIN,  16'h0080, 16'h0000, 5'h11, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_UN, K_ZLOUT, 16'h0000, 16'h0040, 5'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b0, I_UN, 1'b1, 1'b0);

        // Ra=Rb=Rc=15.
        idle(1'b1, I_SAME, 1'b0, 1'b0);
        fetch(I_SAME, 0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_SAME, K_YIN,   16'h8000, 16'h0000, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_SAME, K_ZLIN,  16'h8000, 16'h0000, 5'h0E, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_SAME, K_ZLOUT, 16'h0000, 16'h8000, 5'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b0, I_SAME, 1'b1, 1'b0);

        // Clear (with start also high) during a T1 memory wait, then a normal BIN run.
        idle(1'b1, I_BIN, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_BIN, K_T0,  16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, I_BIN, K_T1F, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, I_BIN, K_T1W, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b0, I_BIN, 1'b0, 1'b0);
        idle(1'b1, I_BIN, 1'b0, 1'b0);
        fetch(I_BIN, 0, 1'b0);
        bin_exec(I_BIN);
        idle(1'b0, I_BIN, 1'b0, 1'b0);

        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; IR = 32'h0;
        repeat (2) @(posedge Clock);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clock);
            start = tbl[i].st; mem_ready = tbl[i].mr; clear = tbl[i].clr; IR = tbl[i].ir;
            #1;
            act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin, ZHighin,
                   Zlowout, Zhighout, HIin, LOin, Rout, Rin, op, busy, done, illegal};
            exp_v = {tbl[i].ctrl, tbl[i].rout, tbl[i].rin, tbl[i].op,
                     tbl[i].busy, tbl[i].done, tbl[i].ill};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL row %0d outputs: got %h expected %h", i, act, exp_v);
            end
            drivers = int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout) + $countones(Rout);
            checks++;
            if (drivers > 1 || !$onehot0(Rin) || (done && illegal)) begin
                errors++;
                $display("FAIL row %0d bus: drivers=%0d Rin=%h done=%b illegal=%b, need drivers<=1 onehot0 Rin not both",
                         i, drivers, Rin, done, illegal);
            end
        end

        @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtype_ctrl_seq.md
Name: rtype_ctrl_seq

Overview:
- Hardwired control sequencer for `data_path`.
- On `start`, fetches one instruction and executes it. Supported instructions: register–register ALU ops (two-operand or one-operand) and MUL/DIV with HI/LO writeback.
- Drives the bus-select and register-enable strobes that are currently hand-toggled in unit benches.
- Sits between the memory interface and `data_path`, one instance per CPU.

Parameters:
- NREGS, 16, number of general registers; width of `Rout`/`Rin`.
- OPW, 5, opcode width and width of `op` to the ALU.

Ports:
- Clock in 1 — rising-edge clock.
- clear in 1 — synchronous, active-high reset.
- start in 1 — begin fetch/execute; sampled only in IDLE.
- mem_ready in 1 — memory data valid on `Mdatain`; qualifies Read.
- IR in 32 — `data_path` IR contents; valid from T3.
- PCout, MARin, IncPC, PCin out 1 — PC path strobes.
- Read, MDRin, MDRout, IRin out 1 — memory/IR strobes.
- Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin out 1 — ALU path strobes.
- Rout out NREGS — one-hot register bus drive.
- Rin out NREGS — one-hot register load.
- op out OPW — ALU operation select.
- busy out 1 — high in any state other than IDLE.
- done out 1 — one-cycle pulse on completion.
- illegal out 1 — one-cycle pulse on unsupported opcode.

Behaviour:
- IR fields: opc=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Opcode classes:
  - 0x00–0x0E: BIN (two-operand).
  - 0x11 (neg), 0x12 (not): UN (one-operand).
  - 0x0F (mul), 0x10 (div): HL (HI/LO writeback).
  - Anything else: ILL.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Moore outputs: every strobe is decoded from the state register and the latched IR only; no combinational path from `start` or `mem_ready` to any output.
- Fetch/execute sequence:
  - IDLE: all strobes 0. start=1 → T0.
  - T0: PCout, MARin, IncPC, Zlowin. → T1.
  - T1: Zlowout, PCin, Read, MDRin.
    - Stays in T1 while mem_ready=0, holding Read=MDRin=1.
    - PCin asserts only in the first T1 cycle, so PC increments exactly once.
    - mem_ready=1 → T2.
  - T2: MDRout, IRin. → T3.
  - T3: the 32-bit `IR` input is latched internally on entry to T3, i.e. the edge leaving T2.
    - BIN/HL: Rout[Rb], Yin. → T4.
    - UN: no strobes. → T4.
    - ILL: illegal pulses. → IDLE.
  - T4: op=opc.
    - BIN: Rout[Rc], Zlowin. → T5.
    - UN: Rout[Rb], Zlowin. → T5.
    - HL: Rout[Rc], Zlowin, ZHighin. → T5.
  - T5:
    - BIN/UN: Zlowout, Rin[Ra]. → IDLE with done.
    - HL: Zlowout, LOin. → T6.
  - T6: Zhighout, HIin. → IDLE with done.
- op: equals opc in T4 only; 0 in all other states.
- Rout/Rin: at most one bit set in each; never set outside the states listed above.
- Single bus driver: at most one *out strobe (including Rout bits) is high in any cycle.
- done/illegal:
  - Registered; high for exactly the cycle after the final/ILL state, in which busy=0.
  - Never both high.
- start while busy: ignored. start held high in IDLE: a new instruction begins on the same edge that completes the previous one's done cycle.
- Reset:
  - clear=1 on a rising edge → state=IDLE, latched IR=0, done=illegal=0.
  - All outputs are 0 from the next cycle; this holds in any state, including a mem_ready wait in T1.
  - clear has priority over start.
- Ra=Rb=Rc is legal: the same one-hot index is used in different cycles.

Test Plan:
- BIN (sll): start, mem_ready=1 in T1, IR=0x18918000 (opc=3, Ra=1, Rb=2, Rc=3).
  - Expect T3 Rout=0x0004+Yin; T4 Rout=0x0008, op=3, Zlowin; T5 Zlowout, Rin=0x0002.
  - done in cycle 7 after start; with R2=12, R3=5 preloaded, R1=384.
- Memory wait: same IR, mem_ready held 0 for 3 cycles in T1.
  - Expect Read=MDRin=1 for 4 cycles and PCin=1 for 1 cycle only; PC increments by 1.
  - done 3 cycles later than the no-wait case.
- HL (mul): IR=0x78228000 (Rb=4, Rc=5).
  - Expect T4 Zlowin=ZHighin=1, op=0x0F; T5 Zlowout+LOin; T6 Zhighout+HIin; Rin=0 throughout.
  - With R4=0x10000, R5=0x30000: HI=3, LO=0.
- ILL: IR=0xF8000000.
  - Expect illegal pulse one cycle after T3, return to IDLE, and no Rin/Yin/Zlowin/ZHighin/HIin/LOin/op activity after T2.
- Reset mid-op: clear=1 for one edge while in T1 waiting.
  - Next cycle: busy=0, all strobes 0, no done.
  - A subsequent start executes IR=0x18918000 normally.
- Bus-conflict checker: across all scenarios, assert ≤1 bus driver per cycle and one-hot Rout/Rin.
